// File: rtl/bwn_pkg.sv
// Shared defaults and fixed-point helpers for the BWN alpha-scale datapath.
package bwn_pkg;

    localparam int BWN_NUM_CH    = 40;
    localparam int BWN_FRAC_BITS = 4;
    localparam int BWN_ACC_W     = 16;
    localparam int BWN_COEF_W    = 16;
    localparam int BWN_OUT_W     = 16;
    localparam int BWN_PROD_W    = BWN_ACC_W + BWN_COEF_W + 1;

    // Round half toward +inf, drop the fraction, clamp to the signed output range.
    function automatic logic [BWN_OUT_W-1:0] sat_round(input logic [BWN_PROD_W-1:0] prod);
        localparam int SW = BWN_PROD_W + 1;
        localparam logic signed [SW-1:0] RND  = (BWN_FRAC_BITS > 0) ?
            (SW'(1) << ((BWN_FRAC_BITS > 0) ? BWN_FRAC_BITS - 1 : 0)) : '0;
        localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (BWN_OUT_W - 1)) - 64'sd1);
        localparam logic signed [SW-1:0] MINV = ~MAXV;
        logic signed [SW-1:0] r;
        r = {prod[BWN_PROD_W-1], prod};
        r = r + RND;
        r = r >>> BWN_FRAC_BITS;
        if (r > MAXV)      return MAXV[BWN_OUT_W-1:0];
        else if (r < MINV) return MINV[BWN_OUT_W-1:0];
        else               return r[BWN_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/bwn_round_sat.sv
// Combinational round / shift / saturate stage for scaled products.
// Optional fused ReLU when BWN_ALPHA_RELU_EN is defined.
module bwn_round_sat
    import bwn_pkg::*;
#(
    parameter int PROD_W    = BWN_PROD_W,
    parameter int FRAC_BITS = BWN_FRAC_BITS,
    parameter int OUT_W     = BWN_OUT_W
) (
    input  logic [PROD_W-1:0] prod,
    output logic [OUT_W-1:0]  res
);

    localparam int SW = PROD_W + 1;
    localparam logic signed [SW-1:0] RND  = (FRAC_BITS > 0) ?
        (SW'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0)) : '0;
    localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [SW-1:0] r;
    logic [OUT_W-1:0]     sat;

    // One guard bit above the product so the rounding add cannot wrap.
    always_comb begin
        r = {prod[PROD_W-1], prod};
        r = r + RND;
        r = r >>> FRAC_BITS;
        if (r > MAXV)      sat = MAXV[OUT_W-1:0];
        else if (r < MINV) sat = MINV[OUT_W-1:0];
        else               sat = r[OUT_W-1:0];
    end

`ifdef BWN_ALPHA_RELU_EN
    assign res = sat[OUT_W-1] ? '0 : sat;
`else
    assign res = sat;
`endif

endmodule

// File: rtl/bwn_alpha_scale.sv
// Per-channel alpha scaling of the binary-conv accumulator stream: ROM address
// from a channel counter, multiply, round/saturate, 2-stage valid/ready pipe.
module bwn_alpha_scale
    import bwn_pkg::*;
#(
    parameter int WIDTH_A   = 12,
    parameter int NUM_CH    = BWN_NUM_CH,
    parameter int ACC_W     = BWN_ACC_W,
    parameter int COEF_W    = BWN_COEF_W,
    parameter int FRAC_BITS = BWN_FRAC_BITS,
    parameter int OUT_W     = BWN_OUT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [ACC_W-1:0]   in_acc,
    output logic [WIDTH_A-1:0] coef_addr,
    input  logic [COEF_W-1:0]  coef,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [WIDTH_A-1:0] out_ch,
    output logic               out_last
);

    localparam int STAGES = 2;
    localparam int PROD_W = ACC_W + COEF_W + 1;
    localparam logic [WIDTH_A-1:0] LAST_CH = WIDTH_A'(NUM_CH - 1);

    logic [STAGES:1]      vld_pipe;
    logic [WIDTH_A-1:0]   ch_cnt, ch_eff, s1_ch;
    logic [PROD_W-1:0]    a_ext, c_ext, prod_c, s1_prod;
    logic [OUT_W-1:0]     rs;
    logic                 adv, accept;

    assign out_valid = vld_pipe[STAGES];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && in_ready;
    assign ch_eff    = in_sof ? '0 : ch_cnt;
    assign coef_addr = ch_eff;

    // Low PROD_W bits of an unsigned multiply equal the signed product once
    // the accumulator is sign-extended and the coefficient zero-extended.
    assign a_ext  = {{(COEF_W + 1){in_acc[ACC_W-1]}}, in_acc};
    assign c_ext  = {{(ACC_W + 1){1'b0}}, coef};
    assign prod_c = a_ext * c_ext;

    bwn_round_sat #(
        .PROD_W    (PROD_W),
        .FRAC_BITS (FRAC_BITS),
        .OUT_W     (OUT_W)
    ) u_round_sat (
        .prod (s1_prod),
        .res  (rs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt   <= '0;
            vld_pipe <= '0;
            s1_prod  <= '0;
            s1_ch    <= '0;
            out_data <= '0;
            out_ch   <= '0;
            out_last <= 1'b0;
        end else begin
            if (accept)
                ch_cnt <= (ch_eff == LAST_CH) ? '0 : ch_eff + 1'b1;
            // Whole pipe moves together; a stalled output freezes both stages.
            if (adv) begin
                vld_pipe <= {vld_pipe[STAGES-1:1], accept};
                s1_prod  <= prod_c;
                s1_ch    <= ch_eff;
                out_data <= rs;
                out_ch   <= s1_ch;
                out_last <= (s1_ch == LAST_CH);
            end
        end
    end

endmodule
